// File: rtl/hdmi_pattern_feeder.sv
`default_nettype none
// ============================================================================
// Module      : hdmi_pattern_feeder
// Description : Video test-pattern and square-wave audio source that feeds
//               the hdmi block over its valid/rdy interfaces.
//               Video patterns: solid, colour bars, gradient, checkerboard.
//               Audio: AUDIO_CH square waves, channel k half-period is
//               TONE_HALF<<k accepted samples.
// Ports       : clk, rst_n (async active-low)
//               start/stop           - streaming control pulses
//               mode, solid_color    - pattern select, sampled at frame start
//               video_out/valid/rdy/sof/eol - pixel stream
//               audio_out/valid/rdy  - multi-channel sample stream
//               frame_count, busy    - status
// Options     : `define FEEDER_FRAME_CRC_EN adds frame_crc / frame_crc_valid
//               (CRC-16-CCITT over every accepted pixel of a frame).
// Revision    : 1.0 - initial release
// ============================================================================
module hdmi_pattern_feeder #(
    parameter int          H_ACTIVE  = 640,
    parameter int          V_ACTIVE  = 480,
    parameter int          COLOR_W   = 8,
    parameter int          AUDIO_W   = 16,
    parameter int          AUDIO_CH  = 2,
    parameter int          TONE_HALF = 24,
    parameter logic [15:0] TONE_AMP  = 16'h2000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        stop,
    input  logic [1:0]                  mode,
    input  logic [3*COLOR_W-1:0]        solid_color,
    output logic [3*COLOR_W-1:0]        video_out,
    output logic                        video_valid,
    input  logic                        video_rdy,
    output logic                        video_sof,
    output logic                        video_eol,
    output logic [AUDIO_CH*AUDIO_W-1:0] audio_out,
    output logic                        audio_valid,
    input  logic                        audio_rdy,
    output logic [15:0]                 frame_count,
    output logic                        busy
`ifdef FEEDER_FRAME_CRC_EN
    ,
    output logic [15:0]                 frame_crc,
    output logic                        frame_crc_valid
`endif
);

    localparam int c_XW    = $clog2(H_ACTIVE);
    localparam int c_YW    = $clog2(V_ACTIVE);
    localparam int c_BAR_W = H_ACTIVE / 8;
    localparam int c_BW    = $clog2(c_BAR_W);
    localparam int c_PW    = 3 * COLOR_W;
    localparam int c_ACW   = $clog2(TONE_HALF << (AUDIO_CH - 1)) + 1;

    localparam logic [AUDIO_W-1:0] c_AMP_POS = AUDIO_W'(TONE_AMP);
    localparam logic [AUDIO_W-1:0] c_AMP_NEG = -c_AMP_POS;

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_RUN       = 2'd1;
    localparam logic [1:0] c_STOP_PEND = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [c_XW-1:0] x_q, x_d;
    logic [c_YW-1:0] y_q, y_d;
    logic [c_BW-1:0] bar_cnt_q, bar_cnt_d;
    logic [2:0]      bar_idx_q, bar_idx_d;
    logic [1:0]      mode_q, mode_d;
    logic [c_PW-1:0] solid_q, solid_d;
    logic [c_PW-1:0] pix_q, pix_d;
    logic            sof_q, eol_q;
    logic [15:0]     frame_count_q;

    logic            w_start_ok, w_vxfer, w_axfer, w_last_x, w_last_y;
    logic            w_frame_done, w_to_idle, w_load, w_y3;
    logic [2:0]      w_bar_rgb;
    logic [COLOR_W-1:0] w_grad;

    assign w_start_ok   = (state_q == c_IDLE) && start;
    assign w_vxfer      = video_valid && video_rdy;
    assign w_axfer      = audio_valid && audio_rdy;
    assign w_last_x     = (x_q == c_XW'(H_ACTIVE - 1));
    assign w_last_y     = (y_q == c_YW'(V_ACTIVE - 1));
    assign w_frame_done = w_vxfer && w_last_x && w_last_y;
    assign w_to_idle    = (state_q == c_STOP_PEND) && w_frame_done;
    assign w_load       = w_start_ok || w_vxfer;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= c_IDLE;
        else        state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:      if (start)     state_d = c_RUN;
            c_RUN:       if (stop)      state_d = c_STOP_PEND;
            c_STOP_PEND: if (w_to_idle) state_d = c_IDLE;
            default:                    state_d = c_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        video_valid = 1'b0;
        audio_valid = 1'b0;
        busy        = 1'b0;
        if (state_q != c_IDLE) begin
            video_valid = 1'b1;
            audio_valid = 1'b1;
            busy        = 1'b1;
        end
    end

    // Next raster position; pattern selection is re-sampled only when (0,0)
    // is about to be presented so a frame never mixes two patterns.
    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        bar_cnt_d = bar_cnt_q;
        bar_idx_d = bar_idx_q;
        mode_d    = mode_q;
        solid_d   = solid_q;
        if (w_start_ok) begin
            x_d       = '0;
            y_d       = '0;
            bar_cnt_d = '0;
            bar_idx_d = '0;
            mode_d    = mode;
            solid_d   = solid_color;
        end else if (w_vxfer) begin
            if (w_last_x) begin
                x_d       = '0;
                bar_cnt_d = '0;
                bar_idx_d = '0;
                if (w_last_y) begin
                    y_d     = '0;
                    mode_d  = mode;
                    solid_d = solid_color;
                end else begin
                    y_d = y_q + c_YW'(1);
                end
            end else begin
                x_d = x_q + c_XW'(1);
                if (bar_cnt_q == c_BW'(c_BAR_W - 1)) begin
                    bar_cnt_d = '0;
                    bar_idx_d = bar_idx_q + 3'd1;
                end else begin
                    bar_cnt_d = bar_cnt_q + c_BW'(1);
                end
            end
        end
    end

    // Checkerboard needs bit 3 of y; short frames have no such bit.
    if (c_YW > 3) begin : g_y3
        assign w_y3 = y_d[3];
    end else begin : g_y3_zero
        assign w_y3 = 1'b0;
    end

    always_comb begin
        w_grad = '0;
        for (int i = 0; i < COLOR_W; i++) begin
            if (i < c_XW) w_grad[i] = x_d[i];
        end
    end

    // Bar order white..black as {r,g,b} on/off flags
    always_comb begin
        case (bar_idx_d)
            3'd0:    w_bar_rgb = 3'b111;
            3'd1:    w_bar_rgb = 3'b110;
            3'd2:    w_bar_rgb = 3'b011;
            3'd3:    w_bar_rgb = 3'b010;
            3'd4:    w_bar_rgb = 3'b101;
            3'd5:    w_bar_rgb = 3'b100;
            3'd6:    w_bar_rgb = 3'b001;
            default: w_bar_rgb = 3'b000;
        endcase
    end

    always_comb begin
        case (mode_d)
            2'd0:    pix_d = solid_d;
            2'd1:    pix_d = {{COLOR_W{w_bar_rgb[2]}}, {COLOR_W{w_bar_rgb[1]}},
                              {COLOR_W{w_bar_rgb[0]}}};
            2'd2:    pix_d = {3{w_grad}};
            default: pix_d = (x_d[3] ^ w_y3) ? '0 : '1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q           <= '0;
            y_q           <= '0;
            bar_cnt_q     <= '0;
            bar_idx_q     <= '0;
            mode_q        <= '0;
            solid_q       <= '0;
            pix_q         <= '0;
            sof_q         <= 1'b0;
            eol_q         <= 1'b0;
            frame_count_q <= '0;
        end else begin
            if (w_load) begin
                x_q       <= x_d;
                y_q       <= y_d;
                bar_cnt_q <= bar_cnt_d;
                bar_idx_q <= bar_idx_d;
                mode_q    <= mode_d;
                solid_q   <= solid_d;
                pix_q     <= pix_d;
                sof_q     <= (x_d == '0) && (y_d == '0);
                eol_q     <= (x_d == c_XW'(H_ACTIVE - 1));
            end
            if (w_frame_done) frame_count_q <= frame_count_q + 16'd1;
            // Outputs return to zero once streaming halts
            if (w_to_idle) begin
                pix_q <= '0;
                sof_q <= 1'b0;
                eol_q <= 1'b0;
            end
        end
    end

    assign video_out   = pix_q;
    assign video_sof   = sof_q;
    assign video_eol   = eol_q;
    assign frame_count = frame_count_q;

    // ---------------- audio: one phase counter per channel ----------------
    for (genvar k = 0; k < AUDIO_CH; k++) begin : g_ch
        localparam int c_LIM = (TONE_HALF << k) - 1;
        logic [c_ACW-1:0] cnt_q;
        logic             pol_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
                pol_q <= 1'b0;
            end else if (w_start_ok) begin
                cnt_q <= '0;
                pol_q <= 1'b0;
            end else if (w_axfer) begin
                if (cnt_q == c_ACW'(c_LIM)) begin
                    cnt_q <= '0;
                    pol_q <= ~pol_q;
                end else begin
                    cnt_q <= cnt_q + c_ACW'(1);
                end
            end
        end

        assign audio_out[k*AUDIO_W +: AUDIO_W] =
            !audio_valid ? '0 : (pol_q ? c_AMP_NEG : c_AMP_POS);
    end

`ifdef FEEDER_FRAME_CRC_EN
    // CRC-16-CCITT, MSB first over the {r,g,b} word
    function automatic logic [15:0] crc_step(input logic [15:0] c,
                                             input logic [c_PW-1:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = c_PW - 1; i >= 0; i--) begin
            fb = r[15] ^ d[i];
            r  = {r[14:0], 1'b0};
            if (fb) r = r ^ 16'h1021;
        end
        return r;
    endfunction

    logic [15:0] crc_q, frame_crc_q, w_crc_next;
    logic        frame_crc_valid_q;

    assign w_crc_next = crc_step(sof_q ? 16'hFFFF : crc_q, pix_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q             <= 16'hFFFF;
            frame_crc_q       <= '0;
            frame_crc_valid_q <= 1'b0;
        end else begin
            frame_crc_valid_q <= 1'b0;
            if (w_vxfer) begin
                crc_q <= w_crc_next;
                if (w_last_x && w_last_y) begin
                    frame_crc_q       <= w_crc_next;
                    frame_crc_valid_q <= 1'b1;
                end
            end
        end
    end

    assign frame_crc       = frame_crc_q;
    assign frame_crc_valid = frame_crc_valid_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hdmi_pattern_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_hdmi_pattern_feeder
// Description : Scoreboard bench for hdmi_pattern_feeder at 16x4, 2 channels,
//               TONE_HALF=2. Stimulus pushes expected pixels/samples; the
//               monitor pops and compares on every accepted transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hdmi_pattern_feeder;
    localparam int H = 16, V = 4, CW = 8, AW = 16, CH = 2, TH = 2;

    logic              clk = 1'b0;
    logic              rst_n, start, stop, video_rdy, audio_rdy;
    logic [1:0]        mode;
    logic [3*CW-1:0]   solid_color, video_out;
    logic              video_valid, video_sof, video_eol, audio_valid, busy;
    logic [CH*AW-1:0]  audio_out;
    logic [15:0]       frame_count;
`ifdef FEEDER_FRAME_CRC_EN
    logic [15:0]       frame_crc;
    logic              frame_crc_valid;
    logic [15:0]       crc_got[$];
`endif

    always #5 clk = ~clk;

    hdmi_pattern_feeder #(
        .H_ACTIVE(H), .V_ACTIVE(V), .COLOR_W(CW), .AUDIO_W(AW),
        .AUDIO_CH(CH), .TONE_HALF(TH), .TONE_AMP(16'h2000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
        .solid_color(solid_color), .video_out(video_out),
        .video_valid(video_valid), .video_rdy(video_rdy),
        .video_sof(video_sof), .video_eol(video_eol),
        .audio_out(audio_out), .audio_valid(audio_valid),
        .audio_rdy(audio_rdy), .frame_count(frame_count), .busy(busy)
`ifdef FEEDER_FRAME_CRC_EN
        , .frame_crc(frame_crc), .frame_crc_valid(frame_crc_valid)
`endif
    );

    int n_chk = 0;
    int n_fail = 0;

    logic [25:0] vid_q[$];
    logic [31:0] aud_q[$];
    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] exp_pix(input int m, input logic [23:0] s,
                                            input int x, input int y);
        logic [7:0] g;
        case (m)
            0:       return s;
            1:       return bars[x / (H / 8)];
            2:       begin g = 8'(x); return {g, g, g}; end
            default: return ((((x >> 3) ^ (y >> 3)) & 1) != 0) ? 24'h000000 : 24'hFFFFFF;
        endcase
    endfunction

    task automatic push_frame(input int m, input logic [23:0] s);
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++)
                vid_q.push_back({exp_pix(m, s, x, y), (x == 0 && y == 0), (x == H - 1)});
    endtask

    // ch0 flips every 2 samples, ch1 every 4; both start at +0x2000
    task automatic push_audio();
        logic [15:0] c0, c1;
        aud_q.delete();
        for (int n = 0; n < 32; n++) begin
            c0 = (((n / 2) % 2) != 0) ? 16'hE000 : 16'h2000;
            c1 = (((n / 4) % 2) != 0) ? 16'hE000 : 16'h2000;
            aud_q.push_back({c1, c0});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        push_audio();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic wait_q(input int n);
        int k;
        k = 0;
        while (vid_q.size() > n && k < 500) begin tick(); k++; end
        if (vid_q.size() > n) begin
            n_chk++; n_fail++;
            $display("FAIL wait_q_timeout: queue %0d required <= %0d", vid_q.size(), n);
        end
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy && k < 1000) begin tick(); k++; end
        if (busy) begin
            n_chk++; n_fail++;
            $display("FAIL %s_timeout: busy still 1 required 0", name);
        end
        chk({name, "_video_drained"}, 64'(vid_q.size()), 64'd0);
        chk({name, "_audio_drained"}, 64'(aud_q.size()), 64'd0);
        chk({name, "_valid_low"}, {62'd0, video_valid, audio_valid}, 64'd0);
    endtask

    // ---------------- monitor ----------------
    logic        prev_stall = 1'b0;
    logic [25:0] prev_v;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && video_valid)
                chk("stall_hold", {video_out, video_sof, video_eol}, prev_v);
            if (video_valid && video_rdy) begin
                if (vid_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL video_extra: got pixel %h with nothing expected", video_out);
                end else begin
                    chk("video_pixel", {video_out, video_sof, video_eol}, vid_q.pop_front());
                end
            end
            prev_stall = video_valid && !video_rdy;
            prev_v     = {video_out, video_sof, video_eol};
            if (audio_valid && audio_rdy && aud_q.size() > 0)
                chk("audio_sample", audio_out, aud_q.pop_front());
`ifdef FEEDER_FRAME_CRC_EN
            if (frame_crc_valid) crc_got.push_back(frame_crc);
`endif
        end
    end

`ifdef FEEDER_FRAME_CRC_EN
    function automatic logic [15:0] model_crc(input int m);
        logic [15:0] r;
        logic [23:0] p;
        logic        fb;
        r = 16'hFFFF;
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++) begin
                p = exp_pix(m, 24'h0, x, y);
                for (int i = 23; i >= 0; i--) begin
                    fb = r[15] ^ p[i];
                    r  = {r[14:0], 1'b0};
                    if (fb) r = r ^ 16'h1021;
                end
            end
        return r;
    endfunction
`endif

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 2'd0;
        solid_color = 24'h0; video_rdy = 1'b1; audio_rdy = 1'b1;
        tick(); tick();
        chk("rst_video_out", video_out, 64'd0);
        chk("rst_flags", {video_valid, video_sof, video_eol, audio_valid, busy}, 64'd0);
        chk("rst_audio_out", audio_out, 64'd0);
        chk("rst_frame_count", frame_count, 64'd0);
        rst_n = 1'b1;
        tick();

        // colour bars, full frame then halt
        mode = 2'd1;
        push_frame(1, 24'h0);
        pulse_start();
        pulse_stop();
        wait_idle("bars");
        chk("bars_frame_count", frame_count, 64'd1);

        // gradient with both sinks stalling every other cycle
        mode = 2'd2;
        push_frame(2, 24'h0);
        pulse_start();
        pulse_stop();
        for (int k = 0; k < 400 && busy; k++) begin
            video_rdy = ~video_rdy;
            audio_rdy = ~audio_rdy;
            tick();
        end
        video_rdy = 1'b1;
        audio_rdy = 1'b1;
        wait_idle("grad");
        chk("grad_frame_count", frame_count, 64'd2);

        // checkerboard, mode switched to solid mid-frame
        mode = 2'd3;
        push_frame(3, 24'h0);
        push_frame(0, 24'h123456);
        pulse_start();
        repeat (20) tick();
        mode = 2'd0;
        solid_color = 24'h123456;
        wait_q(63);
        pulse_stop();
        wait_idle("modechg");
        chk("modechg_frame_count", frame_count, 64'd4);

        // stop at pixel 10: frame still completes
        mode = 2'd1;
        push_frame(1, 24'h0);
        pulse_start();
        wait_q(54);
        pulse_stop();
        wait_idle("stop10");
        chk("stop10_frame_count", frame_count, 64'd5);
        chk("stop10_busy", busy, 64'd0);

        // asynchronous reset mid-line
        push_frame(1, 24'h0);
        pulse_start();
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        chk("arst_video_out", video_out, 64'd0);
        chk("arst_flags", {video_valid, video_sof, video_eol, audio_valid, busy}, 64'd0);
        chk("arst_audio_out", audio_out, 64'd0);
        chk("arst_frame_count", frame_count, 64'd0);
        vid_q.delete();
        aud_q.delete();
        tick();
        rst_n = 1'b1;
        tick();

        // two identical bar frames after reset
        push_frame(1, 24'h0);
        push_frame(1, 24'h0);
        pulse_start();
        wait_q(63);
        pulse_stop();
        wait_idle("post_rst");
        chk("post_rst_frame_count", frame_count, 64'd2);
`ifdef FEEDER_FRAME_CRC_EN
        tick();
        chk("crc_count", 64'(crc_got.size()), 64'd2);
        if (crc_got.size() == 2) begin
            chk("crc_frame0", crc_got[0], model_crc(1));
            chk("crc_frame1", crc_got[1], model_crc(1));
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
`default_nettype wire
